nibble_serial_adder: RTL and testbench

Multi-nibble serial adder that sequences wide operands through the existing 4-bit ripple-carry adder cell, one nibble per clock. It sits directly upstream and downstream of that cell. It drives the cell's A/B/C0 inputs from operand shift registers and captures the S/C4 outputs into a result register, with C4 fed back as the next nibble's carry-in. This gives a 4·NIBBLES-bit add using a single 4-bit adder instance placed alongside it.

---
 rtl/nibble_serial_adder.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a 4*NIBBLES-bit add through an external
// combinational 4-bit ripple-carry cell, one nibble per clock.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed-overflow
// output (ovf) that updates together with sum.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; cell inputs driven to 0
// RUN   | one nibble per cycle presented to the cell, result shifted in
// DONE  | one-cycle done pulse; a new start here begins the next add
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic         ovf,
`endif
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_c0,
    input  logic [3:0]   add_s,
    input  logic         add_c4
);

    localparam int CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   res_sh;
    logic           carry;
    logic [CW-1:0]  nib_left;
    logic           accept;
    logic           last_nib;
`ifdef SERIAL_ADD_OVF_EN
    logic           a_msb;
    logic           b_msb;
`endif

    // start is honoured in IDLE and in DONE (back-to-back), never in RUN
    assign accept   = start && (state != RUN);
    // nibbles remaining is a down-counter; zero means the top nibble is in the cell
    assign last_nib = (state == RUN) && (nib_left == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (nib_left == '0) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags and cell inputs; cell sees zeros outside RUN
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_c0 = 1'b0;
        case (state)
            RUN: begin
                busy   = 1'b1;
                add_a  = a_sh[3:0];
                add_b  = b_sh[3:0];
                add_c0 = carry;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand/result shift registers, carry chain and nibble counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            nib_left <= '0;
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            nib_left <= CW'(NIBBLES - 1);
        end else if (state == RUN) begin
            res_sh   <= {add_s, res_sh[W-1:4]};
            a_sh     <= {4'd0, a_sh[W-1:4]};
            b_sh     <= {4'd0, b_sh[W-1:4]};
            carry    <= add_c4;
            nib_left <= nib_left - 1'b1;
        end
    end

    // Result registers change only on the completing edge (or reset)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_nib) begin
            sum  <= {add_s, res_sh[W-1:4]};
            cout <= add_c4;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Operand sign bits are kept from the start so overflow needs no full copy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[W-1];
                b_msb <= b[W-1];
            end
            if (last_nib) begin
                ovf <= (a_msb == b_msb) && (add_s[3] != a_msb);
            end
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: models the 4-bit adder cell, drives directed
// and random adds, and compares against whole-word arithmetic.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_c0;
    logic [3:0]   add_s;
    logic         add_c4;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
    logic         exp_ovf;
`endif

    int           n_chk;
    int           n_err;
    logic [W-1:0] exp_sum;
    logic         exp_cout;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf    (ovf),
`endif
        .add_a  (add_a),
        .add_b  (add_b),
        .add_c0 (add_c0),
        .add_s  (add_s),
        .add_c4 (add_c4)
    );

    // combinational 4-bit ripple-carry cell
    assign {add_c4, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One add, entered on a falling edge; returns on the falling edge of the DONE cycle.
    // stray=1 pulses start with unrelated operands two cycles into RUN.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input bit stray);
        logic [63:0] full;
        logic [63:0] mask;
        logic [63:0] cin_i;
        full  = 64'(ai) + 64'(bi) + 64'(ci);
        a     = ai;
        b     = bi;
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            mask  = (64'd1 << (4 * i)) - 64'd1;
            cin_i = ((64'(ai) & mask) + (64'(bi) & mask) + 64'(ci)) >> (4 * i);
            chk("busy_run", 64'(busy), 64'd1);
            chk("done_run", 64'(done), 64'd0);
            chk("add_a", 64'(add_a), (64'(ai) >> (4 * i)) & 64'hF);
            chk("add_b", 64'(add_b), (64'(bi) >> (4 * i)) & 64'hF);
            chk("add_c0", 64'(add_c0), cin_i & 64'd1);
            chk("sum_hold", 64'(sum), 64'(exp_sum));
            chk("cout_hold", 64'(cout), 64'(exp_cout));
            if (stray && i == 2) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("sum", 64'(sum), 64'(exp_sum));
        chk("cout", 64'(cout), 64'(exp_cout));
        chk("add_a_done", 64'(add_a), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = (ai[W-1] == bi[W-1]) && (exp_sum[W-1] != ai[W-1]);
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`endif
    endtask

    // After a non-chained DONE: next cycle must be idle with results held
    task automatic idle_after;
        @(negedge clk);
        chk("done_fall", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("sum_idle", 64'(sum), 64'(exp_sum));
        chk("cout_idle", 64'(cout), 64'(exp_cout));
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_cell", {add_a, add_b, add_c0}, 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle_after();
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle_after();
        // back-to-back: start held through the DONE cycle
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        idle_after();
        // start during RUN is ignored
        do_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b1);
        idle_after();
`ifdef SERIAL_ADD_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle_after();
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle_after();
`endif

        // reset in the third RUN cycle aborts the add
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_cell", {add_a, add_b, add_c0}, 64'd0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
            chk("abort_idle", 64'(busy), 64'd0);
        end
        do_op(16'h0F00, 16'h0100, 1'b1, 1'b0);
        idle_after();

        // random adds, some chained back-to-back
        for (int k = 0; k < 30; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
